cmp_hold_scheduler: RTL and testbench

//  Shares one compare-and-hold register (running maximum, unsigned) between NUM_REQ requesters.

---
 rtl/cmp_sched_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 32 +++
 rtl/cmp_hold_scheduler.sv | 146 ++++++++++++++
 tb/tb_cmp_hold_scheduler.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cmp_sched_pkg.sv
// Shared types and constants for the compare-and-hold scheduler.
// Works with the optional statistics counter, which is enabled by defining CMP_HOLD_STATS_EN.
package cmp_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_CMP   = 2'd2
  } state_t;

  localparam int STATS_W     = 16;
  localparam int DEF_DW      = 8;
  localparam int DEF_NUM_REQ = 4;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: the first requester at or after the pointer, wrapping around.
// Purely combinational; the pointer register lives in the scheduler.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDW-1:0]     i_ptr,
  output logic [NUM_REQ-1:0] o_pick,
  output logic [IDW-1:0]     o_id
);

  logic           w_found;
  logic [IDW-1:0] w_idx;

  // Scan requesters starting at the pointer; the first hit wins.
  always_comb begin
    o_pick  = '0;
    o_id    = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      w_idx = IDW'((int'(i_ptr) + off) % NUM_REQ);
      if (!w_found && i_req[w_idx]) begin
        w_found       = 1'b1;
        o_pick[w_idx] = 1'b1;
        o_id          = w_idx;
      end
    end
  end

endmodule

// File: rtl/cmp_hold_scheduler.sv
// Shares one running-maximum register between NUM_REQ requesters.
// Each transaction is IDLE -> GRANT -> CMP, three cycles long.
// The held value is replaced only when the granted operand is strictly greater.
// Defining CMP_HOLD_STATS_EN adds the upd_cnt output, which counts capture events.
//
// Handshake: a requester raises req and keeps both req and its val stable until it sees
// its ack bit. val is sampled only in GRANT. Once a grant is issued the transaction always
// completes, even if req drops. Holding req high after ack joins the next arbitration.
// That requester then ranks behind the others, because the pointer moves past it.
module cmp_hold_scheduler
  import cmp_sched_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int DW      = DEF_DW,
  parameter int IDW     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ*DW-1:0] val,
  input  logic                  clr,
  output logic [NUM_REQ-1:0]    gnt,
  output logic [NUM_REQ-1:0]    ack,
  output logic [DW-1:0]         held_val,
  output logic [IDW-1:0]        held_id,
  output logic                  held_vld,
  output logic                  updated,
  output logic [1:0]            dbg_state
`ifdef CMP_HOLD_STATS_EN
  ,
  output logic [STATS_W-1:0]    upd_cnt
`endif
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [NUM_REQ-1:0] r_gnt;
  logic [IDW-1:0]     r_id;
  logic [IDW-1:0]     r_ptr;
  logic [DW-1:0]      r_opnd;
  logic [DW-1:0]      r_held_val;
  logic [IDW-1:0]     r_held_id;
  logic               r_held_vld;
  logic [NUM_REQ-1:0] w_ack;
  logic               w_upd;
  logic [NUM_REQ-1:0] w_pick;
  logic [IDW-1:0]     w_pick_id;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ),
    .IDW    (IDW)
  ) u_arb (
    .i_req (req),
    .i_ptr (r_ptr),
    .o_pick(w_pick),
    .o_id  (w_pick_id)
  );

  // Next state plus the CMP-cycle ack and update pulses.
  // A clear in the same cycle as CMP suppresses the update.
  always_comb begin
    w_state_nxt = r_state;
    w_ack       = '0;
    w_upd       = 1'b0;
    case (r_state)
      ST_IDLE:  if (|req) w_state_nxt = ST_GRANT;
      ST_GRANT: w_state_nxt = ST_CMP;
      ST_CMP: begin
        w_state_nxt = ST_IDLE;
        w_ack       = r_gnt;
        w_upd       = !clr && (!r_held_vld || (r_opnd > r_held_val));
      end
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Grant, granted id, operand capture, and pointer advance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_gnt  <= '0;
      r_id   <= '0;
      r_ptr  <= '0;
      r_opnd <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|req) begin
            r_gnt <= w_pick;
            r_id  <= w_pick_id;
          end
        end
        ST_GRANT: r_opnd <= val[int'(r_id)*DW +: DW];
        ST_CMP: begin
          r_gnt <= '0;
          r_ptr <= (r_id == IDW'(NUM_REQ-1)) ? '0 : r_id + 1'b1;
        end
        default: r_gnt <= '0;
      endcase
    end
  end

  // Held maximum. A clear has priority over a capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_held_val <= '0;
      r_held_id  <= '0;
      r_held_vld <= 1'b0;
    end else if (clr) begin
      r_held_val <= '0;
      r_held_id  <= '0;
      r_held_vld <= 1'b0;
    end else if (w_upd) begin
      r_held_val <= r_opnd;
      r_held_id  <= r_id;
      r_held_vld <= 1'b1;
    end
  end

`ifdef CMP_HOLD_STATS_EN
  logic [STATS_W-1:0] r_upd_cnt;

  // Count capture events, saturating. A clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                r_upd_cnt <= '0;
    else if (clr)                            r_upd_cnt <= '0;
    else if (w_upd && (r_upd_cnt != '1))     r_upd_cnt <= r_upd_cnt + 1'b1;
  end

  assign upd_cnt = r_upd_cnt;
`endif

  assign gnt       = r_gnt;
  assign ack       = w_ack;
  assign updated   = w_upd;
  assign held_val  = r_held_val;
  assign held_id   = r_held_id;
  assign held_vld  = r_held_vld;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_cmp_hold_scheduler.sv
// Directed bench for cmp_hold_scheduler (NUM_REQ=4, DW=8).
// Covers the upd_cnt output as well when CMP_HOLD_STATS_EN is defined.
module tb_cmp_hold_scheduler;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] val;
  logic        clr;
  logic [3:0]  gnt;
  logic [3:0]  ack;
  logic [7:0]  held_val;
  logic [1:0]  held_id;
  logic        held_vld;
  logic        updated;
  logic [1:0]  dbg_state;
`ifdef CMP_HOLD_STATS_EN
  logic [15:0] upd_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0] exp_q[$];
  logic [3:0] e_gnt;
  logic       exp_upd  [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [7:0] exp_held [5] = '{8'h20, 8'h30, 8'h30, 8'h50, 8'h50};
  logic [1:0] exp_hid  [5] = '{2'd0, 2'd1, 2'd1, 2'd3, 2'd3};

  cmp_hold_scheduler dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .val      (val),
    .clr      (clr),
    .gnt      (gnt),
    .ack      (ack),
    .held_val (held_val),
    .held_id  (held_id),
    .held_vld (held_vld),
    .updated  (updated),
    .dbg_state(dbg_state)
`ifdef CMP_HOLD_STATS_EN
    ,
    .upd_cnt  (upd_cnt)
`endif
  );

  // Clock generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_val(input int idx, input logic [7:0] v);
    val[idx*8 +: 8] = v;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0;
    req = 4'hF;
    val = '0;
    clr = 1'b0;

    // Reset with every requester active.
    step();
    step();
    chk("rst_gnt", gnt, 0);
    chk("rst_ack", ack, 0);
    chk("rst_held_val", held_val, 0);
    chk("rst_held_id", held_id, 0);
    chk("rst_held_vld", held_vld, 0);
    chk("rst_updated", updated, 0);
    chk("rst_state", dbg_state, 0);
`ifdef CMP_HOLD_STATS_EN
    chk("rst_upd_cnt", upd_cnt, 0);
`endif
    rst = 1'b1;
    step();
    chk("rel_gnt", gnt, 4'b0001);
    chk("rel_ack", ack, 0);

    // Reset arriving during GRANT aborts the transaction at once.
    rst = 1'b0;
    #1;
    chk("abort_gnt", gnt, 0);
    chk("abort_ack", ack, 0);
    chk("abort_state", dbg_state, 0);
    step();
    chk("abort_ack2", ack, 0);
    chk("abort_vld", held_vld, 0);
    rst = 1'b1;
    req = 4'b0000;

    // Single requester 2 with 0x10 makes the first capture.
    set_val(2, 8'h10);
    req = 4'b0100;
    step();
    chk("t2_gnt1", gnt, 4'b0100);
    chk("t2_ack1", ack, 0);
    step();
    chk("t2_gnt2", gnt, 4'b0100);
    chk("t2_ack2", ack, 4'b0100);
    chk("t2_upd", updated, 1);
    req = 4'b0000;
    step();
    chk("t2_gnt3", gnt, 0);
    chk("t2_ack3", ack, 0);
    chk("t2_upd3", updated, 0);
    chk("t2_held_val", held_val, 8'h10);
    chk("t2_held_id", held_id, 2);
    chk("t2_held_vld", held_vld, 1);

    // An equal operand, then a smaller one, from requester 1: no capture.
    set_val(1, 8'h10);
    req = 4'b0010;
    step();
    chk("t3a_gnt", gnt, 4'b0010);
    step();
    chk("t3a_ack", ack, 4'b0010);
    chk("t3a_upd", updated, 0);
    req = 4'b0000;
    step();
    chk("t3a_held_val", held_val, 8'h10);
    chk("t3a_held_id", held_id, 2);
    set_val(1, 8'h05);
    req = 4'b0010;
    step();
    chk("t3b_gnt", gnt, 4'b0010);
    step();
    chk("t3b_ack", ack, 4'b0010);
    chk("t3b_upd", updated, 0);
    req = 4'b0000;
    step();
    chk("t3b_held_val", held_val, 8'h10);
    chk("t3b_held_id", held_id, 2);
    chk("t3b_held_vld", held_vld, 1);

    // Reset so the pointer is 0, then hold all requests: rotation is 0,1,2,3,0.
    rst = 1'b0;
    #1;
    rst = 1'b1;
    chk("t4_held_cleared", held_val, 0);
    set_val(0, 8'h20);
    set_val(1, 8'h30);
    set_val(2, 8'h15);
    set_val(3, 8'h50);
    req = 4'hF;
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0100);
    exp_q.push_back(4'b1000);
    exp_q.push_back(4'b0001);
    for (int t = 0; t < 5; t++) begin
      e_gnt = exp_q.pop_front();
      step();
      chk($sformatf("t4_gnt_%0d", t), gnt, e_gnt);
      chk($sformatf("t4_noack_%0d", t), ack, 0);
      step();
      chk($sformatf("t4_ack_%0d", t), ack, e_gnt);
      chk($sformatf("t4_upd_%0d", t), updated, exp_upd[t]);
      step();
      chk($sformatf("t4_idle_gnt_%0d", t), gnt, 0);
      chk($sformatf("t4_held_val_%0d", t), held_val, exp_held[t]);
      chk($sformatf("t4_held_id_%0d", t), held_id, exp_hid[t]);
      if (t == 4) req = 4'b0000;
    end
`ifdef CMP_HOLD_STATS_EN
    chk("t4_upd_cnt", upd_cnt, 3);
`endif

    // Clear coinciding with CMP beats a larger operand.
    set_val(2, 8'hFF);
    req = 4'b0100;
    step();
    chk("t5_gnt", gnt, 4'b0100);
    step();
    clr = 1'b1;
    #1;
    chk("t5_ack", ack, 4'b0100);
    chk("t5_upd", updated, 0);
    req = 4'b0000;
    step();
    clr = 1'b0;
    chk("t5_held_val", held_val, 0);
    chk("t5_held_id", held_id, 0);
    chk("t5_held_vld", held_vld, 0);
    chk("t5_gnt_idle", gnt, 0);
`ifdef CMP_HOLD_STATS_EN
    chk("t5_upd_cnt_clr", upd_cnt, 0);
`endif
    // After a clear, even an operand of zero is captured.
    set_val(0, 8'h00);
    req = 4'b0001;
    step();
    chk("t5b_gnt", gnt, 4'b0001);
    step();
    chk("t5b_ack", ack, 4'b0001);
    chk("t5b_upd", updated, 1);
    req = 4'b0000;
    step();
    chk("t5b_held_vld", held_vld, 1);
    chk("t5b_held_val", held_val, 0);
    chk("t5b_held_id", held_id, 0);
`ifdef CMP_HOLD_STATS_EN
    chk("t5b_upd_cnt", upd_cnt, 1);
`endif

    // Reset during GRANT: grant drops, held state clears, and no ack follows.
    set_val(3, 8'h77);
    req = 4'b1000;
    step();
    chk("t6_gnt", gnt, 4'b1000);
    rst = 1'b0;
    #1;
    chk("t6_gnt_drop", gnt, 0);
    chk("t6_ack_drop", ack, 0);
    chk("t6_held_vld", held_vld, 0);
    chk("t6_state", dbg_state, 0);
    step();
    chk("t6_no_ack", ack, 0);
    chk("t6_no_upd", updated, 0);
`ifdef CMP_HOLD_STATS_EN
    chk("t6_upd_cnt", upd_cnt, 0);
`endif
    rst = 1'b1;
    req = 4'b0000;
    step();
    chk("t6_idle_gnt", gnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
